// File: rtl/vx_dcr_launch_ctrl.sv
// vx_dcr_launch_ctrl
// Kernel-launch sequencer sitting in front of the Vortex wrapper.
// The host stages a small table of DCR writes while the sequencer is idle.
// On start, the table is replayed one entry per cycle onto the DCR write port.
// After a short drain, the core reset is released and the sequencer waits for
// the core to report busy. It then times the run until busy falls, the busy
// wait times out, or the host aborts.
module vx_dcr_launch_ctrl #(
    parameter int NUM_DCRS       = 8,
    parameter int DCR_ADDR_WIDTH = 12,
    parameter int DCR_DATA_WIDTH = 32,
    parameter int DRAIN_CYCLES   = 2,
    parameter int BUSY_TIMEOUT   = 1024,
    parameter int CNT_WIDTH      = 48
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [$clog2(NUM_DCRS)-1:0]   cfg_idx,
    input  logic [DCR_ADDR_WIDTH-1:0]     cfg_addr,
    input  logic [DCR_DATA_WIDTH-1:0]     cfg_data,
    input  logic                          cfg_clear,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic                          abort,
    output logic                          dcr_wr_valid,
    output logic [DCR_ADDR_WIDTH-1:0]     dcr_wr_addr,
    output logic [DCR_DATA_WIDTH-1:0]     dcr_wr_data,
    output logic                          vx_reset,
    input  logic                          busy,
    output logic                          running,
    output logic                          done,
    output logic [1:0]                    err_code,
    output logic [CNT_WIDTH-1:0]          cycle_count
);

    localparam int IDX_W = $clog2(NUM_DCRS);
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 2);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DCRS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ABORT   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PROGRAM     = 3'd1,
        ST_DRAIN       = 3'd2,
        ST_LAUNCH_WAIT = 3'd3,
        ST_RUN         = 3'd4,
        ST_DONE        = 3'd5
    } state_t;

    state_t                       state_r;
    logic [IDX_W-1:0]             idx_r;
    logic [IDX_W-1:0]             idx_nxt_s;
    logic [DRN_W-1:0]             drain_r;
    logic [TMR_W-1:0]             tmr_r;

    // Staging table: registered copy and the value it takes at the next edge.
    logic [NUM_DCRS-1:0]          tbl_valid_r;
    logic [DCR_ADDR_WIDTH-1:0]    tbl_addr_r [NUM_DCRS];
    logic [DCR_DATA_WIDTH-1:0]    tbl_data_r [NUM_DCRS];
    logic [NUM_DCRS-1:0]          tbl_valid_s;
    logic [DCR_ADDR_WIDTH-1:0]    tbl_addr_s [NUM_DCRS];
    logic [DCR_DATA_WIDTH-1:0]    tbl_data_s [NUM_DCRS];

    // Registered outputs.
    logic                         idle_r;
    logic                         dcr_wr_valid_r;
    logic [DCR_ADDR_WIDTH-1:0]    dcr_wr_addr_r;
    logic [DCR_DATA_WIDTH-1:0]    dcr_wr_data_r;
    logic                         vx_reset_r;
    logic                         running_r;
    logic                         done_r;
    logic [1:0]                   err_r;
    logic [CNT_WIDTH-1:0]         cnt_r;

    assign cfg_ready    = idle_r;
    assign start_ready  = idle_r;
    assign dcr_wr_valid = dcr_wr_valid_r;
    assign dcr_wr_addr  = dcr_wr_addr_r;
    assign dcr_wr_data  = dcr_wr_data_r;
    assign vx_reset     = vx_reset_r;
    assign running      = running_r;
    assign done         = done_r;
    assign err_code     = err_r;
    assign cycle_count  = cnt_r;

    assign idx_nxt_s = idx_r + IDX_W'(1'b1);

    // Next table contents: host edits are honoured only while idle.
    // A clear and a write in the same cycle keep just the written entry.
    always_comb begin
        tbl_valid_s = tbl_valid_r;
        for (int i = 0; i < NUM_DCRS; i++) begin
            tbl_addr_s[i] = tbl_addr_r[i];
            tbl_data_s[i] = tbl_data_r[i];
        end
        if (state_r == ST_IDLE) begin
            if (cfg_clear) begin
                tbl_valid_s = {NUM_DCRS{1'b0}};
            end else begin
                tbl_valid_s = tbl_valid_r;
            end
            if (cfg_valid) begin
                tbl_valid_s[cfg_idx] = 1'b1;
                tbl_addr_s[cfg_idx]  = cfg_addr;
                tbl_data_s[cfg_idx]  = cfg_data;
            end else begin
                tbl_valid_s[cfg_idx] = tbl_valid_s[cfg_idx];
            end
        end else begin
            tbl_valid_s = tbl_valid_r;
        end
    end

    // Staging table storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_valid_r <= {NUM_DCRS{1'b0}};
            for (int i = 0; i < NUM_DCRS; i++) begin
                tbl_addr_r[i] <= {DCR_ADDR_WIDTH{1'b0}};
                tbl_data_r[i] <= {DCR_DATA_WIDTH{1'b0}};
            end
        end else begin
            tbl_valid_r <= tbl_valid_s;
            for (int i = 0; i < NUM_DCRS; i++) begin
                tbl_addr_r[i] <= tbl_addr_s[i];
                tbl_data_r[i] <= tbl_data_s[i];
            end
        end
    end

    // Launch sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            idx_r          <= {IDX_W{1'b0}};
            drain_r        <= {DRN_W{1'b0}};
            tmr_r          <= {TMR_W{1'b0}};
            idle_r         <= 1'b1;
            dcr_wr_valid_r <= 1'b0;
            dcr_wr_addr_r  <= {DCR_ADDR_WIDTH{1'b0}};
            dcr_wr_data_r  <= {DCR_DATA_WIDTH{1'b0}};
            vx_reset_r     <= 1'b1;
            running_r      <= 1'b0;
            done_r         <= 1'b0;
            err_r          <= ERR_OK;
            cnt_r          <= {CNT_WIDTH{1'b0}};
        end else begin
            // The DCR port and the done pulse are single-cycle by default.
            done_r         <= 1'b0;
            dcr_wr_valid_r <= 1'b0;
            dcr_wr_addr_r  <= {DCR_ADDR_WIDTH{1'b0}};
            dcr_wr_data_r  <= {DCR_DATA_WIDTH{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (start_valid) begin
                        state_r <= ST_PROGRAM;
                        idle_r  <= 1'b0;
                        err_r   <= ERR_OK;
                        cnt_r   <= {CNT_WIDTH{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        // Entry 0 goes out in the first PROGRAM cycle and must
                        // see a host write made in the accept cycle.
                        if (tbl_valid_s[0]) begin
                            dcr_wr_valid_r <= 1'b1;
                            dcr_wr_addr_r  <= tbl_addr_s[0];
                            dcr_wr_data_r  <= tbl_data_s[0];
                        end else begin
                            dcr_wr_valid_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PROGRAM: begin
                    if (idx_r == LAST_IDX) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_r    <= ST_LAUNCH_WAIT;
                            vx_reset_r <= 1'b0;
                            running_r  <= 1'b1;
                            tmr_r      <= {TMR_W{1'b0}};
                        end else begin
                            state_r <= ST_DRAIN;
                            drain_r <= {DRN_W{1'b0}};
                        end
                    end else begin
                        idx_r <= idx_nxt_s;
                        if (tbl_valid_r[idx_nxt_s]) begin
                            dcr_wr_valid_r <= 1'b1;
                            dcr_wr_addr_r  <= tbl_addr_r[idx_nxt_s];
                            dcr_wr_data_r  <= tbl_data_r[idx_nxt_s];
                        end else begin
                            dcr_wr_valid_r <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_r == DRN_LAST) begin
                        state_r    <= ST_LAUNCH_WAIT;
                        vx_reset_r <= 1'b0;
                        running_r  <= 1'b1;
                        tmr_r      <= {TMR_W{1'b0}};
                    end else begin
                        drain_r <= drain_r + DRN_W'(1'b1);
                    end
                end
                ST_LAUNCH_WAIT: begin
                    // Abort beats busy, busy beats the timeout.
                    if (abort) begin
                        state_r    <= ST_DONE;
                        err_r      <= ERR_ABORT;
                        done_r     <= 1'b1;
                        vx_reset_r <= 1'b1;
                        running_r  <= 1'b0;
                    end else if (busy) begin
                        state_r <= ST_RUN;
                    end else if (tmr_r == TMR_LAST) begin
                        state_r    <= ST_DONE;
                        err_r      <= ERR_TIMEOUT;
                        done_r     <= 1'b1;
                        vx_reset_r <= 1'b1;
                        running_r  <= 1'b0;
                    end else begin
                        tmr_r <= tmr_r + TMR_W'(1'b1);
                    end
                end
                ST_RUN: begin
                    // Every RUN cycle counts, including the one that exits.
                    if (cnt_r != {CNT_WIDTH{1'b1}}) begin
                        cnt_r <= cnt_r + CNT_WIDTH'(1'b1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                    if (abort) begin
                        state_r    <= ST_DONE;
                        err_r      <= ERR_ABORT;
                        done_r     <= 1'b1;
                        vx_reset_r <= 1'b1;
                        running_r  <= 1'b0;
                    end else if (!busy) begin
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                        vx_reset_r <= 1'b1;
                        running_r  <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    idle_r  <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    idle_r     <= 1'b1;
                    vx_reset_r <= 1'b1;
                    running_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vx_dcr_launch_ctrl.sv
// Self-checking bench for vx_dcr_launch_ctrl: a launch-level reference model
// is compared against every output on every falling edge, directed scenarios
// pin known latencies and values, then randomized traffic runs.
module tb_vx_dcr_launch_ctrl;

    localparam int N  = 8;
    localparam int D  = 2;
    localparam int T  = 16;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int CW = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid, cfg_clear, start_valid, abort, busy;
    logic [2:0]    cfg_idx;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          cfg_ready, start_ready, dcr_wr_valid, vx_reset, running, done;
    logic [AW-1:0] dcr_wr_addr;
    logic [DW-1:0] dcr_wr_data;
    logic [1:0]    err_code;
    logic [CW-1:0] cycle_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    vx_dcr_launch_ctrl #(
        .NUM_DCRS(N), .DCR_ADDR_WIDTH(AW), .DCR_DATA_WIDTH(DW),
        .DRAIN_CYCLES(D), .BUSY_TIMEOUT(T), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_clear(cfg_clear),
        .start_valid(start_valid), .start_ready(start_ready), .abort(abort),
        .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
        .vx_reset(vx_reset), .busy(busy), .running(running), .done(done),
        .err_code(err_code), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_t: 0 when idle, otherwise cycles since the start was accepted
    // (1..N replay entry m_t-1, N+1..N+D drain); after that the launch is
    // tracked by m_wait / m_run, and m_done marks the completion cycle.
    logic          m_tv [N];
    logic [AW-1:0] m_ta [N];
    logic [DW-1:0] m_td [N];
    int            m_t, m_tmr;
    bit            m_wait, m_run, m_done;
    logic [1:0]    m_err;
    logic [CW-1:0] m_cnt;

    task automatic model_reset();
        m_t = 0; m_tmr = 0; m_wait = 0; m_run = 0; m_done = 0;
        m_err = 2'b00; m_cnt = '0;
        for (int i = 0; i < N; i++) begin
            m_tv[i] = 1'b0; m_ta[i] = '0; m_td[i] = '0;
        end
    endtask

    task automatic model_step();
        bit fin;
        fin = 0;
        if (m_done) begin
            m_done = 0; m_t = 0;
        end else if (m_t == 0) begin
            if (cfg_clear) for (int i = 0; i < N; i++) m_tv[i] = 1'b0;
            if (cfg_valid) begin
                m_tv[cfg_idx] = 1'b1; m_ta[cfg_idx] = cfg_addr; m_td[cfg_idx] = cfg_data;
            end
            if (start_valid) begin
                m_t = 1; m_err = 2'b00; m_cnt = '0;
            end
        end else if (!m_wait && !m_run) begin
            m_t = m_t + 1;
            if (m_t > N + D) begin m_wait = 1; m_tmr = 0; end
        end else begin
            if (m_run && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
            if (abort) begin
                m_err = 2'b10; fin = 1;
            end else if (m_run) begin
                if (!busy) fin = 1;
            end else if (busy) begin
                m_run = 1; m_wait = 0;
            end else if (m_tmr == T - 1) begin
                m_err = 2'b01; fin = 1;
            end else begin
                m_tmr = m_tmr + 1;
            end
            if (fin) begin m_done = 1; m_wait = 0; m_run = 0; end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin : compare
        logic          prog, idle, e_dv;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        prog = !m_done && m_t >= 1 && m_t <= N;
        idle = !m_done && m_t == 0;
        e_dv = 1'b0; e_a = '0; e_d = '0;
        if (prog) begin
            if (m_tv[m_t-1]) begin
                e_dv = 1'b1; e_a = m_ta[m_t-1]; e_d = m_td[m_t-1];
            end
        end
        chk("dcr_wr_valid", dcr_wr_valid, e_dv);
        chk("dcr_wr_addr",  dcr_wr_addr,  e_a);
        chk("dcr_wr_data",  dcr_wr_data,  e_d);
        chk("cfg_ready",    cfg_ready,    idle);
        chk("start_ready",  start_ready,  idle);
        chk("vx_reset",     vx_reset,     !(m_wait || m_run));
        chk("running",      running,      m_wait || m_run);
        chk("done",         done,         m_done);
        chk("err_code",     err_code,     m_err);
        chk("cycle_count",  cycle_count,  m_cnt);
    end

    // ---------------- stimulus helpers ----------------
    logic [AW-1:0] cap_addr [64];
    logic [DW-1:0] cap_data [64];

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic quiet();
        cfg_valid = 0; cfg_clear = 0; start_valid = 0; abort = 0;
    endtask

    task automatic stage(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_valid = 1; cfg_idx = 3'(idx); cfg_addr = a; cfg_data = d;
        tick();
        cfg_valid = 0;
    endtask

    task automatic do_start();
        start_valid = 1;
        tick();
        start_valid = 0;
    endtask

    // Called in cycle 1 after an accept; walks to the reset release.
    task automatic run_to_release(output logic [63:0] seen, output int k);
        seen = '0;
        k = 1;
        while (vx_reset === 1'b1 && k < 40) begin
            if (dcr_wr_valid === 1'b1) begin
                seen[k] = 1'b1; cap_addr[k] = dcr_wr_addr; cap_data[k] = dcr_wr_data;
            end
            tick();
            k++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [63:0] seen;
        int k, n;
        rst = 1; busy = 0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        quiet();
        model_reset();
        repeat (3) tick();
        rst = 0;
        tick();
        // Reset state
        chk("rst_vx_reset", vx_reset, 1'b1);
        chk("rst_dcr_valid", dcr_wr_valid, 1'b0);
        chk("rst_start_ready", start_ready, 1'b1);
        chk("rst_err", err_code, 2'b00);
        chk("rst_count", cycle_count, 48'd0);

        // A/B: two staged entries, replay timing, 100-cycle run
        stage(0, 12'h001, 32'h8000_0000);
        stage(3, 12'h002, 32'h0000_1000);
        do_start();
        run_to_release(seen, k);
        chk("A_mask", seen, 64'h12);
        chk("A_release_lat", k, 11);
        chk("A_e0_addr", cap_addr[1], 12'h001);
        chk("A_e0_data", cap_data[1], 32'h8000_0000);
        chk("A_e3_addr", cap_addr[4], 12'h002);
        chk("A_e3_data", cap_data[4], 32'h0000_1000);
        busy = 1;
        repeat (100) tick();
        busy = 0;
        tick();
        chk("B_done", done, 1'b1);
        chk("B_count", cycle_count, 48'd100);
        chk("B_err", err_code, 2'b00);
        chk("B_vx_reset", vx_reset, 1'b1);
        chk("B_running", running, 1'b0);
        tick();
        chk("B_done_once", done, 1'b0);
        chk("B_count_held", cycle_count, 48'd100);

        // C: busy never rises -> timeout after T wait cycles
        do_start();
        run_to_release(seen, k);
        chk("C_release_lat", k, 11);
        wait_done(n);
        chk("C_timeout_lat", n, 16);
        chk("C_err", err_code, 2'b01);
        tick();
        chk("C_err_held", err_code, 2'b01);
        do_start();
        chk("C_err_cleared", err_code, 2'b00);

        // D: abort in the same cycle busy falls during RUN
        run_to_release(seen, k);
        busy = 1;
        repeat (5) tick();
        abort = 1; busy = 0;
        tick();
        abort = 0;
        chk("D_done", done, 1'b1);
        chk("D_err", err_code, 2'b10);
        tick();
        chk("D_done_once", done, 1'b0);

        // E: clear+write, and a write during RUN is ignored
        cfg_clear = 1;
        stage(2, 12'h0AB, 32'h1234_5678);
        cfg_clear = 0;
        do_start();
        run_to_release(seen, k);
        chk("E_mask", seen, 64'h8);
        chk("E_e2_data", cap_data[3], 32'h1234_5678);
        busy = 1;
        repeat (2) tick();
        stage(5, 12'h555, 32'hDEAD_BEEF);
        busy = 0;
        wait_done(n);
        tick();
        do_start();
        run_to_release(seen, k);
        chk("E_mask_after_run_write", seen, 64'h8);
        abort = 1;
        tick();
        abort = 0;
        tick();

        // F: reset during replay of entry 4
        do_start();
        repeat (4) tick();
        rst = 1;
        model_reset();
        tick();
        chk("F_dcr_valid", dcr_wr_valid, 1'b0);
        chk("F_vx_reset", vx_reset, 1'b1);
        chk("F_done", done, 1'b0);
        rst = 0;
        repeat (3) begin
            tick();
            chk("F_no_done", done, 1'b0);
        end
        do_start();
        run_to_release(seen, k);
        chk("F_mask_empty", seen, 64'h0);
        abort = 1;
        tick();
        abort = 0;
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            cfg_valid   = ($urandom_range(0, 9) < 3);
            cfg_clear   = ($urandom_range(0, 29) == 0);
            cfg_idx     = 3'($urandom_range(0, N - 1));
            cfg_addr    = AW'($urandom);
            cfg_data    = $urandom;
            start_valid = ($urandom_range(0, 9) == 0);
            abort       = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) busy = ~busy;
            if (rst) begin
                rst = 0;
            end else if ($urandom_range(0, 499) == 0) begin
                rst = 1;
                model_reset();
            end
            tick();
        end
        rst = 0; busy = 0;
        quiet();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
